uart_tx_framer: RTL and testbench

//  Serial transmit framer that consumes the 1-clk bit-rate strobe 'strb' from the prescaler.

---
 rtl/uart_tx_framer_if.sv | 15 +
 rtl/uart_tx_framer.sv | 155 +++++++++++++++
 tb/tb_uart_tx_framer.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_framer_if.sv
// Parallel word handshake between the transmit source and the UART framer.
//   tx_data  : word to send, only meaningful while tx_valid is high
//   tx_valid : source offers tx_data
//   tx_ready : framer holding register is empty; a word is taken on tx_valid & tx_ready
// master modport is the source side, slave modport is the framer side.
interface uart_tx_framer_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmit framer. Takes parallel words through a one-deep holding register and
// serialises each as start bit, data LSB-first, optional parity and 1 or 2 stop bits.
// Every bit lasts one interval of the prescaler strobe 'strb'.
//   clk  : system clock, all state on posedge
//   rst  : asynchronous active-high reset, aborts any frame and empties the holding register
//   strb : one-clk bit-rate tick, period >= 2 clk
//   src  : valid/ready word handshake (slave side)
//   txd  : registered serial line, idle high
//   busy : frame in progress
//   done : one-clk pulse on the edge that ends the last stop bit
module uart_tx_framer #(
    parameter int unsigned DATA_W     = 8,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          PARITY_ODD = 1'b0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            strb,
    uart_tx_framer_if.slave src,
    output logic            txd,
    output logic            busy,
    output logic            done
);

    localparam int unsigned CntW = $clog2(DATA_W);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] hold_q;
    logic              hold_full_q;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CntW-1:0]   bitcnt_q, bitcnt_d;
    logic              stopcnt_q, stopcnt_d;
    logic              parity_q, parity_d;
    logic              txd_q, txd_d;
    logic              done_q, done_d;
    logic              accept;
    logic              load;
    logic              last_data;
    logic              last_stop;

    // Ready is the registered "empty" flag, so accept and load can never share an edge.
    assign src.tx_ready = ~hold_full_q;
    assign accept       = src.tx_valid & ~hold_full_q;
    assign last_data    = (bitcnt_q == CntW'(DATA_W - 1));
    assign last_stop    = (stopcnt_q == 1'(STOP_BITS - 1));

    assign txd  = txd_q;
    assign done = done_q;
    assign busy = (state_q != StIdle);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the FSM only moves on strobe edges
    always_comb begin
        state_d = state_q;
        if (strb) begin
            case (state_q)
                StIdle:   if (hold_full_q) state_d = StStart;
                StStart:  state_d = StData;
                StData:   if (last_data) state_d = PARITY_EN ? StParity : StStop;
                StParity: state_d = StStop;
                StStop:   if (last_stop) state_d = hold_full_q ? StStart : StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    // Output and datapath next values
    always_comb begin
        load      = 1'b0;
        shift_d   = shift_q;
        bitcnt_d  = bitcnt_q;
        stopcnt_d = stopcnt_q;
        parity_d  = parity_q;
        txd_d     = txd_q;
        done_d    = 1'b0;
        if (strb) begin
            case (state_q)
                StIdle: load = hold_full_q;
                StStart: begin
                    txd_d    = shift_q[0];
                    bitcnt_d = '0;
                end
                StData: begin
                    if (last_data) begin
                        txd_d     = PARITY_EN ? parity_q : 1'b1;
                        stopcnt_d = 1'b0;
                    end else begin
                        shift_d  = shift_q >> 1;
                        txd_d    = shift_q[1];
                        bitcnt_d = bitcnt_q + CntW'(1);
                    end
                end
                StParity: begin
                    txd_d     = 1'b1;
                    stopcnt_d = 1'b0;
                end
                StStop: begin
                    if (last_stop) begin
                        done_d = 1'b1;
                        txd_d  = 1'b1;
                        // Back-to-back: the next start bit begins on this same strobe
                        load   = hold_full_q;
                    end else begin
                        stopcnt_d = stopcnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (load) begin
            shift_d  = hold_q;
            parity_d = (^hold_q) ^ PARITY_ODD;
            txd_d    = 1'b0;
        end
    end

    // Datapath and holding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            stopcnt_q   <= 1'b0;
            parity_q    <= 1'b0;
            txd_q       <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            if (accept) begin
                hold_q      <= src.tx_data;
                hold_full_q <= 1'b1;
            end else if (load) begin
                hold_full_q <= 1'b0;
            end
            shift_q   <= shift_d;
            bitcnt_q  <= bitcnt_d;
            stopcnt_q <= stopcnt_d;
            parity_q  <= parity_d;
            txd_q     <= txd_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: dut0 uses defaults (8 data, even parity, 1 stop),
// dut1 uses odd parity and 2 stop bits. A frame-level model (each frame is a bit list
// shown one strobe period per bit) is checked against both DUTs on every negedge.
module tb_uart_tx_framer;

    logic clk = 1'b0;
    logic rst;
    logic strb = 1'b0;
    logic txd0, busy0, done0;
    logic txd1, busy1, done1;

    uart_tx_framer_if #(.DATA_W(8)) if0 ();
    uart_tx_framer_if #(.DATA_W(8)) if1 ();

    uart_tx_framer #(.DATA_W(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .strb(strb), .src(if0.slave),
        .txd(txd0), .busy(busy0), .done(done0)
    );

    uart_tx_framer #(.DATA_W(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .strb(strb), .src(if1.slave),
        .txd(txd1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    bit strb_en = 1'b0;
    bit rnd_strb = 1'b0;
    int sc = 0;
    int gap = 16;
    int done_cnt [2];

    // Behavioural model state
    logic [15:0] m_frame [2];
    int          m_len [2];
    int          m_pos [2];
    bit          m_full [2];
    logic [7:0]  m_hold [2];
    bit          m_done [2];
    bit          m_acc [2];

    // Frame bit k is the line level during strobe period k; unused high bits are stop level.
    function automatic logic [15:0] frame_of(input logic [7:0] w, input bit odd);
        logic [15:0] f;
        f      = 16'hFFFF;
        f[0]   = 1'b0;
        f[8:1] = w;
        f[9]   = (^w) ^ odd;
        return f;
    endfunction

    function automatic int len_of(input int i);
        return (i == 0) ? 11 : 12;
    endfunction

    function automatic bit vld(input int i);
        return (i == 0) ? if0.tx_valid : if1.tx_valid;
    endfunction

    function automatic logic [7:0] dat(input int i);
        return (i == 0) ? if0.tx_data : if1.tx_data;
    endfunction

    // Strobe generator: fixed 16-clk period or random 2..6 clk gaps
    always @(negedge clk) begin
        strb = 1'b0;
        if (!strb_en) begin
            sc = 0;
        end else if (sc >= gap) begin
            strb = 1'b1;
            sc   = 1;
            gap  = rnd_strb ? int'($urandom_range(2, 6)) : 16;
        end else begin
            sc++;
        end
    end

    bit acc;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_len[i]  = 0;
                m_pos[i]  = 0;
                m_full[i] = 1'b0;
                m_done[i] = 1'b0;
                m_acc[i]  = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                acc       = vld(i) && !m_full[i];
                m_done[i] = 1'b0;
                if (strb) begin
                    if (m_len[i] != 0) begin
                        m_pos[i]++;
                        if (m_pos[i] == m_len[i]) begin
                            m_len[i]  = 0;
                            m_done[i] = 1'b1;
                        end
                    end
                    if (m_len[i] == 0 && m_full[i]) begin
                        m_frame[i] = frame_of(m_hold[i], i == 1);
                        m_len[i]   = len_of(i);
                        m_pos[i]   = 0;
                        m_full[i]  = 1'b0;
                    end
                end
                if (acc) begin
                    m_full[i] = 1'b1;
                    m_hold[i] = dat(i);
                end
                m_acc[i] = acc;
            end
        end
    end

    logic [3:0] exp_v, act_v;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                exp_v = {(m_len[i] != 0) ? m_frame[i][m_pos[i]] : 1'b1,
                         !m_full[i], m_len[i] != 0, m_done[i]};
                act_v = (i == 0) ? {txd0, if0.tx_ready, busy0, done0}
                                 : {txd1, if1.tx_ready, busy1, done1};
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL model dut%0d {txd,ready,busy,done} got %b expected %b at %0t",
                             i, act_v, exp_v, $time);
                end
            end
            if (done0) done_cnt[0]++;
            if (done1) done_cnt[1]++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int id, input bit v, input logic [7:0] d);
        if (id == 0) begin
            if0.tx_valid = v;
            if0.tx_data  = d;
        end else begin
            if1.tx_valid = v;
            if1.tx_data  = d;
        end
    endtask

    // Offer a word and return at the negedge after it was accepted
    task automatic send(input int id, input logic [7:0] w);
        int n;
        n = 0;
        @(negedge clk);
        drive(id, 1'b1, w);
        @(negedge clk);
        while (!m_acc[id] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!m_acc[id]) begin
            checks++;
            errors++;
            $display("FAIL send dut%0d word %0h not accepted within 3000 clk", id, w);
        end
        drive(id, 1'b0, 8'($urandom));
    endtask

    task automatic wait_strb(input int n);
        int t;
        for (int k = 0; k < n; k++) begin
            t = 0;
            do begin
                @(posedge clk);
                t++;
            end while (!strb && t < 200);
            if (!strb) begin
                checks++;
                errors++;
                $display("FAIL wait_strb no strobe within 200 clk at %0t", $time);
            end
        end
        @(negedge clk);
    endtask

    task automatic sample_frame(input int id, input int n, output logic [15:0] seq);
        seq = '1;
        for (int k = 0; k < n; k++) begin
            wait_strb(1);
            seq[k] = (id == 0) ? txd0 : txd1;
        end
    endtask

    task automatic wait_done0();
        int n;
        n = 0;
        while (!done0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("done0 seen", done0, 1);
    endtask

    task automatic rand_stream(input int id, input int n);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                // Offer junk only while the register is full, then withdraw it
                if (m_full[id]) begin
                    drive(id, 1'b1, 8'($urandom));
                    @(negedge clk);
                    drive(id, 1'b0, 8'($urandom));
                end
            end
            send(id, 8'($urandom));
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    logic [15:0] seq;
    logic [15:0] pin;

    initial begin
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        rst = 1'b1;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        @(posedge clk);
        #1 chk_en = 1'b1;

        // Reset held 5 clk without strobes
        repeat (5) @(negedge clk);
        check("t1 txd", txd0, 1);
        check("t1 ready", if0.tx_ready, 1);
        check("t1 busy", busy0, 0);
        check("t1 done", done0, 0);
        rst = 1'b0;

        // Hand-computed frames pin the model
        pin = frame_of(8'hA5, 1'b0);
        check("pin A5 even", pin[10:0], 11'h54A);
        pin = frame_of(8'h01, 1'b1);
        check("pin 01 odd", pin[11:0], 12'hC02);

        strb_en = 1'b1;

        // 0xA5 default frame
        send(0, 8'hA5);
        sample_frame(0, 11, seq);
        check("t2 frame A5", seq[10:0], 11'h54A);
        wait_strb(1);
        check("t2 done", done0, 1);
        check("t2 busy", busy0, 0);
        repeat (2) @(negedge clk);
        check("t2 done count", done_cnt[0], 1);

        // 0x00 then 0xFF back-to-back
        done_cnt[0] = 0;
        send(0, 8'h00);
        send(0, 8'hFF);
        check("t3 ready held", if0.tx_ready, 0);
        wait_done0();
        check("t3 b2b start", txd0, 0);
        check("t3 b2b busy", busy0, 1);
        check("t3 ready after load", if0.tx_ready, 1);
        @(negedge clk);
        wait_done0();
        repeat (2) @(negedge clk);
        check("t3 done count", done_cnt[0], 2);

        // Odd parity, two stop bits
        done_cnt[1] = 0;
        send(1, 8'h01);
        sample_frame(1, 12, seq);
        check("t4 frame 01", seq[11:0], 12'hC02);
        check("t4 no early done", done1, 0);
        wait_strb(1);
        check("t4 done", done1, 1);
        check("t4 busy", busy1, 0);
        repeat (2) @(negedge clk);
        check("t4 done count", done_cnt[1], 1);

        // Reset during data bit 3 with a word held
        send(0, 8'h3C);
        send(0, 8'h55);
        wait_strb(4);
        check("t5 pre busy", busy0, 1);
        check("t5 pre ready", if0.tx_ready, 0);
        check("t5 pre txd bit3", txd0, 1);
        #2 rst = 1'b1;
        #1;
        check("t5 txd async", txd0, 1);
        check("t5 ready async", if0.tx_ready, 1);
        check("t5 busy async", busy0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send(0, 8'h81);
        sample_frame(0, 11, seq);
        check("t5 frame 81", seq[10:0], 11'h502);
        wait_strb(1);
        check("t5 done", done0, 1);

        // Strobe stopped: word is held, line stays idle
        strb_en = 1'b0;
        @(negedge clk);
        send(0, 8'h12);
        repeat (20) @(negedge clk);
        check("t6 ready", if0.tx_ready, 0);
        check("t6 txd", txd0, 1);
        check("t6 busy", busy0, 0);
        strb_en = 1'b1;
        sample_frame(0, 11, seq);
        check("t6 frame 12", seq[10:0], 11'h424);
        wait_strb(1);

        // Random traffic on both instances with random strobe gaps
        rnd_strb = 1'b1;
        fork
            rand_stream(0, 25);
            rand_stream(1, 25);
        join
        repeat (400) @(negedge clk);
        check("end idle dut0", busy0, 0);
        check("end idle dut1", busy1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
